// File: rtl/iterative_karatsuba_mult_hs.sv
// Iterative Karatsuba multiplier: one (N/2+1)-bit square core is reused for the
// high, low and middle partial products, then recombined and sign-corrected.
module iterative_karatsuba_mult_hs #(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   C
);

    localparam int unsigned H = N / 2;
    localparam int unsigned W = 2 * N + 2;

    typedef enum logic [2:0] {StIdle, StHh, StLl, StMid, StFin} state_e;

    state_e           state_q;
    logic [N-1:0]     x_q, y_q;
    logic [N-1:0]     hh_q, ll_q;
    logic [N+1:0]     mid_q;
    logic             neg_q;
    logic             done_q;
    logic [2*N-1:0]   c_q;

    // Operand magnitudes; -(2^(N-1)) wraps to 2^(N-1), which is the correct unsigned magnitude.
    logic [N-1:0] a_mag, b_mag;
    assign a_mag = (signed_mode && A[N-1]) ? -A : A;
    assign b_mag = (signed_mode && B[N-1]) ? -B : B;

    // Shared multiplier core, operands steered by the current phase.
    logic [H:0]   core_a, core_b;
    logic [N+1:0] core_p;

    always_comb begin
        core_a = '0;
        core_b = '0;
        case (state_q)
            StHh: begin
                core_a = {1'b0, x_q[N-1:H]};
                core_b = {1'b0, y_q[N-1:H]};
            end
            StLl: begin
                core_a = {1'b0, x_q[H-1:0]};
                core_b = {1'b0, y_q[H-1:0]};
            end
            StMid: begin
                core_a = {1'b0, x_q[N-1:H]} + {1'b0, x_q[H-1:0]};
                core_b = {1'b0, y_q[N-1:H]} + {1'b0, y_q[H-1:0]};
            end
            default: begin
                core_a = '0;
                core_b = '0;
            end
        endcase
    end

    assign core_p = {{(H + 1){1'b0}}, core_a} * {{(H + 1){1'b0}}, core_b};

    // Recombination; mid - hh - ll is the non-negative cross term.
    logic [W-1:0]   hh_w, ll_w, mid_w, p_full;
    logic [2*N-1:0] prod, c_next;
    logic           unused_p_hi;

    assign hh_w        = {{(N + 2){1'b0}}, hh_q};
    assign ll_w        = {{(N + 2){1'b0}}, ll_q};
    assign mid_w       = {{N{1'b0}}, mid_q};
    assign p_full      = (hh_w << N) + ((mid_w - hh_w - ll_w) << H) + ll_w;
    assign prod        = p_full[2*N-1:0];
    assign unused_p_hi = ^p_full[W-1:2*N];
    assign c_next      = neg_q ? -prod : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            hh_q    <= '0;
            ll_q    <= '0;
            mid_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            // done is a single-cycle pulse even while stalled
            done_q <= 1'b0;
            if (enable) begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            x_q     <= a_mag;
                            y_q     <= b_mag;
                            neg_q   <= signed_mode & (A[N-1] ^ B[N-1]);
                            state_q <= StHh;
                        end
                    end
                    StHh: begin
                        hh_q    <= core_p[N-1:0];
                        state_q <= StLl;
                    end
                    StLl: begin
                        ll_q    <= core_p[N-1:0];
                        state_q <= StMid;
                    end
                    StMid: begin
                        mid_q   <= core_p;
                        state_q <= StFin;
                    end
                    StFin: begin
                        c_q     <= c_next;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = ~ready;
    assign done  = done_q;
    assign C     = c_q;

endmodule
